rf_wport_arbiter: RTL and testbench
===================================

RF_WPORT_ARBITER -- requirements
Module: cv32e40x_rf_wport_arbiter

Interface
REQ-001 SHALL have parameter XRES_DEPTH, default 2, result-buffer entries (power of 2, >=2).
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, consecutive buffer-losing cycles before buffer is forced.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port wb_we_i  input  1  WB stage requests regfile write.
REQ-006 SHALL have port wb_waddr_i  input  5 (rf_addr_t)  WB destination register.
REQ-007 SHALL have port wb_wdata_i  input  32  WB write data.
REQ-008 SHALL have port wb_stall_o  output  1  WB write denied this cycle; controller holds WB (halt_wb).
REQ-009 SHALL have port xres_valid_i  input  1  coprocessor result valid.
REQ-010 SHALL have port xres_ready_o  output  1  result accepted when valid&&ready.
REQ-011 SHALL have port xres_we_i  input  1  result carries a register write.
REQ-012 SHALL have port xres_rd_i  input  5  result destination register.
REQ-013 SHALL have port xres_data_i  input  32  result data.
REQ-014 SHALL have port rf_we_o  output  1  regfile write enable.
REQ-015 SHALL have port rf_waddr_o  output  5  regfile write address.
REQ-016 SHALL have port rf_wdata_o  output  32  regfile write data.
REQ-017 SHALL have port xres_empty_o  output  1  buffer empty; controller uses it before debug entry and sleep.

Function
REQ-018 SHALL buffer accepted results in an XRES_DEPTH FIFO with a count, read/write pointers and pointer wrap-around.
REQ-019 SHALL drive xres_ready_o = !full from registered count only; full with same-cycle pop still deasserts ready.
REQ-020 SHALL drop accepted results with xres_we_i=0 or xres_rd_i=0 (handshake completes, nothing stored).
REQ-021 SHALL have no bypass; a result accepted in cycle N reaches rf_we_o no earlier than N+1.
REQ-022 SHALL grant the port to WB when wb_we_i=1 and buffer empty.
REQ-023 SHALL grant the port to the buffer head when buffer non-empty and wb_we_i=0.
REQ-024 SHALL grant WB on conflict (both pending) while starve_cnt < STARVE_LIMIT, and the buffer when starve_cnt == STARVE_LIMIT.
REQ-025 SHALL assert wb_stall_o only when wb_we_i=1 and the buffer is granted; WB inputs stay stable upstream.
REQ-026 SHALL increment starve_cnt (saturating at STARVE_LIMIT) each cycle the buffer is non-empty and not granted.
REQ-027 SHALL clear starve_cnt whenever the buffer head is popped.
REQ-028 SHALL pop the head exactly on the cycle it is granted; push and pop in one cycle leave count unchanged.
REQ-029 SHALL drive rf_we_o=0 with no grant; rf_waddr_o/rf_wdata_o then follow WB inputs.
REQ-030 SHALL drive rf_* combinationally from the granted source (WB inputs or head entry).

Reset
REQ-031 SHALL on rst_n=0 clear count, pointers and starve_cnt; buffer contents need no reset.
REQ-032 SHALL during and after reset give rf_we_o=0, wb_stall_o=0, xres_ready_o=1, xres_empty_o=1.
REQ-033 SHALL discard all buffered results on reset mid-operation; no write follows.

Structure
REQ-034 SHALL define xres_entry_t {rf_addr_t rd; logic [31:0] data} in cv32e40x_pkg; rf_addr_t from cv32e40x_pkg.
REQ-035 SHALL place FIFO storage/pointers in one sub-module cv32e40x_xres_fifo; arbitration and starve_cnt stay in the top.

Verification
REQ-036 SHALL cover: reset released, idle -> rf_we_o=0, xres_ready_o=1, xres_empty_o=1.
REQ-037 SHALL cover: result rd=5 data=0xA5A5A5A5 in cycle N, wb_we_i=0 -> rf_we_o=1, waddr=5, wdata=0xA5A5A5A5 in N+1 only.
REQ-038 SHALL cover: depth 2, results rd=1,2,3 back-to-back, wb_we_i=1 continuously -> ready low after 2 accepts; rd=1 written on 5th conflict cycle with wb_stall_o=1; rd=2 and rd=3 each 5 cycles after their predecessor.
REQ-039 SHALL cover: result rd=0 and result xres_we_i=0 accepted -> no rf write, xres_empty_o stays 1.
REQ-040 SHALL cover: buffer full, rst_n pulsed low mid-cycle -> outputs at reset values immediately; no stale write after release.

Source files
------------

// File: rtl/rf_wport_arbiter_pkg.sv
// Shared types for the register-file write-port arbiter.
//   rf_addr_t    : 5-bit integer register index
//   xres_entry_t : one buffered coprocessor result (destination + data)
package rf_wport_arbiter_pkg;

  typedef logic [4:0] rf_addr_t;

  typedef struct packed {
    rf_addr_t    rd;
    logic [31:0] data;
  } xres_entry_t;

  // x0 is hardwired to zero, so results targeting it are never stored
  localparam rf_addr_t RF_ADDR_ZERO = 5'd0;

endpackage

// File: rtl/rf_wport_arbiter_xres_fifo.sv
// Result buffer for coprocessor writebacks.
// Ports:
//   clk, rst_n  : clock, async active-low reset (clears count/pointers only)
//   push        : store push_entry at the write pointer (caller ensures !full)
//   push_entry  : entry to store
//   pop         : advance the read pointer (caller ensures !empty)
//   head        : entry at the read pointer
//   full, empty : derived from the registered count
module rf_wport_arbiter_xres_fifo
  import rf_wport_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  xres_entry_t push_entry,
  input  logic        pop,
  output xres_entry_t head,
  output logic        full,
  output logic        empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [PW:0]   count;
  xres_entry_t   mem [DEPTH];

  // DEPTH is a power of two, so pointers wrap by plain overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; count gating makes stale contents unobservable
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= push_entry;
  end

  assign head  = mem[rptr];
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

endmodule

// File: rtl/rf_wport_arbiter.sv
// Register-file write-port arbiter between the WB stage and buffered
// coprocessor results.
// Ports:
//   clk, rst_n                        : clock, async active-low reset
//   wb_we_i/wb_waddr_i/wb_wdata_i     : WB stage write request
//   wb_stall_o                        : WB denied this cycle (port given to buffer)
//   xres_valid_i/xres_ready_o         : result handshake
//   xres_we_i/xres_rd_i/xres_data_i   : result payload
//   rf_we_o/rf_waddr_o/rf_wdata_o     : regfile write port
//   xres_empty_o                      : no buffered results pending
module rf_wport_arbiter
  import rf_wport_arbiter_pkg::*;
#(
  parameter int unsigned XRES_DEPTH   = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_we_i,
  input  rf_addr_t    wb_waddr_i,
  input  logic [31:0] wb_wdata_i,
  output logic        wb_stall_o,
  input  logic        xres_valid_i,
  output logic        xres_ready_o,
  input  logic        xres_we_i,
  input  rf_addr_t    xres_rd_i,
  input  logic [31:0] xres_data_i,
  output logic        rf_we_o,
  output rf_addr_t    rf_waddr_o,
  output logic [31:0] rf_wdata_o,
  output logic        xres_empty_o
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          buf_grant;
  xres_entry_t   push_entry;
  xres_entry_t   head;
  logic [SW-1:0] starve_cnt;

  assign push_entry = '{rd: xres_rd_i, data: xres_data_i};

  // Ready comes from the registered count only: a full buffer refuses a
  // result even if its head pops this cycle.
  assign xres_ready_o = !fifo_full;

  // Results without a real destination complete the handshake but are dropped
  assign push = xres_valid_i && xres_ready_o && xres_we_i && (xres_rd_i != RF_ADDR_ZERO);

  rf_wport_arbiter_xres_fifo #(
    .DEPTH (XRES_DEPTH)
  ) u_xres_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (buf_grant),
    .head       (head),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  // WB normally wins; the buffer takes the port once it has lost
  // STARVE_LIMIT conflict cycles in a row.
  assign buf_grant = !fifo_empty && (!wb_we_i || (starve_cnt == STARVE_MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (buf_grant) begin
      starve_cnt <= '0;
    end else if (!fifo_empty && (starve_cnt != STARVE_MAX)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  assign wb_stall_o   = wb_we_i && buf_grant;
  assign rf_we_o      = wb_we_i || buf_grant;
  assign rf_waddr_o   = buf_grant ? head.rd   : wb_waddr_i;
  assign rf_wdata_o   = buf_grant ? head.data : wb_wdata_i;
  assign xres_empty_o = fifo_empty;

endmodule

// File: tb/tb_rf_wport_arbiter.sv
module tb_rf_wport_arbiter;
  import rf_wport_arbiter_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        wb_we_i;
  rf_addr_t    wb_waddr_i;
  logic [31:0] wb_wdata_i;
  logic        wb_stall_o;
  logic        xres_valid_i;
  logic        xres_ready_o;
  logic        xres_we_i;
  rf_addr_t    xres_rd_i;
  logic [31:0] xres_data_i;
  logic        rf_we_o;
  rf_addr_t    rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic        xres_empty_o;

  rf_wport_arbiter #(
    .XRES_DEPTH   (2),
    .STARVE_LIMIT (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wb_we_i      (wb_we_i),
    .wb_waddr_i   (wb_waddr_i),
    .wb_wdata_i   (wb_wdata_i),
    .wb_stall_o   (wb_stall_o),
    .xres_valid_i (xres_valid_i),
    .xres_ready_o (xres_ready_o),
    .xres_we_i    (xres_we_i),
    .xres_rd_i    (xres_rd_i),
    .xres_data_i  (xres_data_i),
    .rf_we_o      (rf_we_o),
    .rf_waddr_o   (rf_waddr_o),
    .rf_wdata_o   (rf_wdata_o),
    .xres_empty_o (xres_empty_o)
  );

  typedef struct {
    int          cyc;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        stall;
  } exp_t;

  exp_t q[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: classifies each write as WB or buffer and checks buffer writes
  // against the scoreboard queue, including the cycle they appear in.
  always @(negedge clk) begin
    if (wb_stall_o && !rf_we_o) begin
      n_assert++;
      n_fail++;
      $display("FAIL stall_without_write: got stall=1 we=0 expected no stall (cycle %0d)", cyc);
    end
    if (rf_we_o) begin
      if (wb_we_i && !wb_stall_o) begin
        chk("wb_waddr", 32'(rf_waddr_o), 32'(wb_waddr_i));
        chk("wb_wdata", rf_wdata_o, wb_wdata_i);
      end else if (q.size() == 0) begin
        n_assert++;
        n_fail++;
        $display("FAIL unexpected_write: got write rd=%0d data=%h expected none (cycle %0d)",
                 rf_waddr_o, rf_wdata_o, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("buf_cycle", 32'(cyc), 32'(e.cyc));
        chk("buf_waddr", 32'(rf_waddr_o), 32'(e.rd));
        chk("buf_wdata", rf_wdata_o, e.data);
        chk("buf_stall", 32'(wb_stall_o), 32'(e.stall));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst_n        = 1'b0;
    wb_we_i      = 1'b0;
    wb_waddr_i   = '0;
    wb_wdata_i   = '0;
    xres_valid_i = 1'b0;
    xres_we_i    = 1'b0;
    xres_rd_i    = '0;
    xres_data_i  = '0;

    // Reset values while held in reset
    #3;
    chk("rst_rf_we", 32'(rf_we_o), 0);
    chk("rst_stall", 32'(wb_stall_o), 0);
    chk("rst_ready", 32'(xres_ready_o), 1);
    chk("rst_empty", 32'(xres_empty_o), 1);
    #9 rst_n = 1'b1;

    // Idle after release
    tick();
    @(negedge clk);
    chk("idle_rf_we", 32'(rf_we_o), 0);
    chk("idle_ready", 32'(xres_ready_o), 1);
    chk("idle_empty", 32'(xres_empty_o), 1);

    // Single result, no WB: written in N+1 only
    tick();
    xres_valid_i = 1'b1; xres_we_i = 1'b1; xres_rd_i = 5'd5; xres_data_i = 32'hA5A5_A5A5;
    n = cyc;
    q.push_back('{n + 1, 5'd5, 32'hA5A5_A5A5, 1'b0});
    tick();
    xres_valid_i = 1'b0;
    @(negedge clk);
    chk("single_empty_n1", 32'(xres_empty_o), 0);
    tick();
    @(negedge clk);
    chk("single_empty_n2", 32'(xres_empty_o), 1);
    tick();

    // Starvation: WB writing every cycle, three results back-to-back
    tick();
    wb_we_i = 1'b1; wb_waddr_i = 5'd7; wb_wdata_i = 32'hDEAD_0007;
    xres_valid_i = 1'b1; xres_we_i = 1'b1; xres_rd_i = 5'd1; xres_data_i = 32'h1111_1111;
    n = cyc;
    q.push_back('{n + 5,  5'd1, 32'h1111_1111, 1'b1});
    q.push_back('{n + 10, 5'd2, 32'h2222_2222, 1'b1});
    q.push_back('{n + 15, 5'd3, 32'h3333_3333, 1'b1});
    tick();
    xres_rd_i = 5'd2; xres_data_i = 32'h2222_2222;
    @(negedge clk);
    chk("starve_ready_n1", 32'(xres_ready_o), 1);
    tick();
    xres_rd_i = 5'd3; xres_data_i = 32'h3333_3333;
    @(negedge clk);
    chk("starve_ready_n2", 32'(xres_ready_o), 0);
    repeat (3) tick();
    @(negedge clk);
    chk("starve_ready_n5", 32'(xres_ready_o), 0);
    tick();
    @(negedge clk);
    chk("starve_ready_n6", 32'(xres_ready_o), 1);
    tick();
    xres_valid_i = 1'b0;
    repeat (9) tick();
    wb_we_i = 1'b0;
    tick();

    // Push and pop in the same cycle, no WB
    tick();
    xres_valid_i = 1'b1; xres_we_i = 1'b1; xres_rd_i = 5'd10; xres_data_i = 32'hA0A0_000A;
    n = cyc;
    q.push_back('{n + 1, 5'd10, 32'hA0A0_000A, 1'b0});
    q.push_back('{n + 2, 5'd11, 32'hA0A0_000B, 1'b0});
    q.push_back('{n + 3, 5'd12, 32'hA0A0_000C, 1'b0});
    tick();
    xres_rd_i = 5'd11; xres_data_i = 32'hA0A0_000B;
    tick();
    xres_rd_i = 5'd12; xres_data_i = 32'hA0A0_000C;
    tick();
    xres_valid_i = 1'b0;
    @(negedge clk);
    chk("pp_empty_n3", 32'(xres_empty_o), 0);
    tick();
    @(negedge clk);
    chk("pp_empty_n4", 32'(xres_empty_o), 1);

    // Dropped results: rd=0 and we=0
    tick();
    xres_valid_i = 1'b1; xres_we_i = 1'b1; xres_rd_i = 5'd0; xres_data_i = 32'hBAD0_0000;
    tick();
    xres_we_i = 1'b0; xres_rd_i = 5'd9; xres_data_i = 32'hBAD0_0009;
    @(negedge clk);
    chk("drop_rd0_empty", 32'(xres_empty_o), 1);
    tick();
    xres_valid_i = 1'b0;
    @(negedge clk);
    chk("drop_we0_empty", 32'(xres_empty_o), 1);
    chk("drop_ready", 32'(xres_ready_o), 1);
    repeat (2) tick();

    // Fill the buffer behind WB, then reset mid-cycle
    tick();
    wb_we_i = 1'b1; wb_waddr_i = 5'd7; wb_wdata_i = 32'hDEAD_0007;
    xres_valid_i = 1'b1; xres_we_i = 1'b1; xres_rd_i = 5'd20; xres_data_i = 32'h0000_0020;
    tick();
    xres_rd_i = 5'd21; xres_data_i = 32'h0000_0021;
    tick();
    xres_valid_i = 1'b0;
    @(negedge clk);
    chk("full_ready", 32'(xres_ready_o), 0);
    chk("full_empty", 32'(xres_empty_o), 0);
    tick();
    wb_we_i = 1'b0;
    rst_n   = 1'b0;
    #1;
    chk("midrst_rf_we", 32'(rf_we_o), 0);
    chk("midrst_stall", 32'(wb_stall_o), 0);
    chk("midrst_ready", 32'(xres_ready_o), 1);
    chk("midrst_empty", 32'(xres_empty_o), 1);
    repeat (2) tick();
    #3 rst_n = 1'b1;
    repeat (8) tick();
    @(negedge clk);
    chk("post_rst_rf_we", 32'(rf_we_o), 0);
    chk("post_rst_ready", 32'(xres_ready_o), 1);
    chk("post_rst_empty", 32'(xres_empty_o), 1);
    chk("scoreboard_drained", 32'(q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
